frame_timing_monitor: RTL and testbench

//  Measures video frame timing (pixels/line, lines/frame, line and frame blanking, frame period)

---
 rtl/frame_timing_monitor_if.sv | 34 +++
 rtl/frame_timing_monitor.sv | 229 ++++++++++++++++++++++
 tb/tb_frame_timing_monitor.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/frame_timing_monitor_if.sv
// Video timing bundle: raw capture qualifiers in, measured timing and status out.
interface frame_timing_monitor_if #(
   parameter int TIMER_BITS = 32
);
   logic                  dvalid;
   logic                  lvalid;
   logic                  fvalid;
   logic [TIMER_BITS-1:0] hsize;
   logic [TIMER_BITS-1:0] vsize;
   logic [TIMER_BITS-1:0] hblank;
   logic [TIMER_BITS-1:0] vblank;
   logic [TIMER_BITS-1:0] frame_period;
   logic [15:0]           frame_cnt;
   logic                  meas_valid;
   logic                  line_err;
   logic                  locked;
   logic                  update;
   logic                  changed;
   logic                  lost;

   // Video source side: drives qualifiers, observes results
   modport master (
      output dvalid, lvalid, fvalid,
      input  hsize, vsize, hblank, vblank, frame_period, frame_cnt,
      input  meas_valid, line_err, locked, update, changed, lost
   );

   // Monitor side
   modport slave (
      input  dvalid, lvalid, fvalid,
      output hsize, vsize, hblank, vblank, frame_period, frame_cnt,
      output meas_valid, line_err, locked, update, changed, lost
   );
endinterface

// File: rtl/frame_timing_monitor.sv
// Frame timing monitor: measures line/frame geometry, blanking and period from
// dvalid/lvalid/fvalid, publishes one measurement per frame at the following
// frame start, qualifies lock over STABLE_FRAMES identical clean frames and
// flags loss of signal when no frame start arrives within TIMEOUT cycles.
module frame_timing_monitor #(
   parameter int TIMER_BITS    = 32,
   parameter int STABLE_FRAMES = 3,
   parameter int TIMEOUT       = 2**24
) (
   input  logic                  clk_in,
   input  logic                  reset,
   frame_timing_monitor_if.slave mon
);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int STB_W = 4;

   typedef logic [TIMER_BITS-1:0] cnt_t;
   typedef enum logic {ARM, MEASURE} state_t;

   function automatic cnt_t sat_inc(input cnt_t v);
      return (v == '1) ? v : v + cnt_t'(1);
   endfunction

   logic dv_r_q, lv_r_q, fv_r_q, lv_d_q, fv_d_q;
   logic fstart, lstart, lend, pix_en, hb_en, publish, expire, diff;

   state_t     state_q, state_d;
   cnt_t       pix_q, pix_d, hb_q, hb_d, vb_q, vb_d, per_q, per_d, lines_q, lines_d;
   cnt_t       hsize_cur_q, hsize_cur_d, hblank_cur_q, hblank_cur_d;
   logic       err_q, err_d, line_seen_q, line_seen_d, fstart_d_q, fstart_d_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [STB_W-1:0] stable_q, stable_d;
   cnt_t       hsize_q, hsize_d, vsize_q, vsize_d, hblank_q, hblank_d;
   cnt_t       vblank_q, vblank_d, frame_period_q, frame_period_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic       meas_valid_q, meas_valid_d, line_err_q, line_err_d, locked_q, locked_d;
   logic       update_q, update_d, changed_q, changed_d, lost_q, lost_d;

   // Input sampling plus one extra stage for edge detection
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         dv_r_q <= 1'b0;
         lv_r_q <= 1'b0;
         fv_r_q <= 1'b0;
         lv_d_q <= 1'b0;
         fv_d_q <= 1'b0;
      end else begin
         dv_r_q <= mon.dvalid;
         lv_r_q <= mon.lvalid;
         fv_r_q <= mon.fvalid;
         lv_d_q <= lv_r_q;
         fv_d_q <= fv_r_q;
      end
   end

   assign fstart  = fv_r_q & ~fv_d_q;
   assign lstart  = lv_r_q & ~lv_d_q;
   // a line ending together with fvalid still belongs to the ending frame
   assign lend    = ~lv_r_q & lv_d_q & fv_d_q;
   assign pix_en  = dv_r_q & lv_r_q & fv_r_q;
   // horizontal blanking only counts once the frame has produced a line
   assign hb_en   = fv_r_q & ~lv_r_q & (line_seen_q | lend);
   assign expire  = (tmo_q == TMO_W'(TIMEOUT - 1));
   assign publish = fstart & (state_q == MEASURE) & ~expire;
   assign diff    = (hsize_cur_q != hsize_q) | (lines_q != vsize_q) |
                    (hblank_cur_q != hblank_q) | (vb_q != vblank_q) |
                    (per_q != frame_period_q);

   // Measurement counters, publish, lock qualification and timeout FSM
   always_comb begin
      state_d        = state_q;
      pix_d          = pix_q;
      hb_d           = hb_q;
      vb_d           = vb_q;
      per_d          = sat_inc(per_q);
      lines_d        = lines_q;
      hsize_cur_d    = hsize_cur_q;
      hblank_cur_d   = hblank_cur_q;
      err_d          = err_q;
      line_seen_d    = line_seen_q;
      fstart_d_d     = fstart;
      tmo_d          = tmo_q;
      stable_d       = stable_q;
      hsize_d        = hsize_q;
      vsize_d        = vsize_q;
      hblank_d       = hblank_q;
      vblank_d       = vblank_q;
      frame_period_d = frame_period_q;
      frame_cnt_d    = frame_cnt_q;
      meas_valid_d   = meas_valid_q;
      line_err_d     = line_err_q;
      locked_d       = locked_q;
      update_d       = 1'b0;
      changed_d      = 1'b0;
      lost_d         = 1'b0;

      if (lstart)      pix_d = pix_en ? cnt_t'(1) : '0;
      else if (pix_en) pix_d = sat_inc(pix_q);

      if (lstart) begin
         if (line_seen_q && !fstart) hblank_cur_d = hb_q;
         hb_d = '0;
      end else if (fstart) begin
         hb_d = '0;
      end else if (hb_en) begin
         hb_d = sat_inc(hb_q);
      end

      if (fstart_d_q)   vb_d = '0;
      else if (!fv_r_q) vb_d = sat_inc(vb_q);

      if (fstart) per_d = cnt_t'(1);

      if (fstart)                        tmo_d = '0;
      else if (tmo_q != TMO_W'(TIMEOUT)) tmo_d = tmo_q + TMO_W'(1);

      if (lend && !fstart) begin
         lines_d     = sat_inc(lines_q);
         line_seen_d = 1'b1;
         if (!line_seen_q)         hsize_cur_d = pix_q;
         else if (pix_q != hsize_cur_q) err_d = 1'b1;
      end

      if (publish) begin
         hsize_d        = hsize_cur_q;
         vsize_d        = lines_q;
         hblank_d       = hblank_cur_q;
         vblank_d       = vb_q;
         frame_period_d = per_q;
         line_err_d     = err_q;
         meas_valid_d   = 1'b1;
         update_d       = 1'b1;
         frame_cnt_d    = frame_cnt_q + 16'd1;
         changed_d      = meas_valid_q & diff;
         if (changed_d || err_q)                     stable_d = '0;
         else if (stable_q != STB_W'(STABLE_FRAMES)) stable_d = stable_q + STB_W'(1);
         locked_d       = (stable_d == STB_W'(STABLE_FRAMES));
      end

      // new frame: per-frame accumulators restart (ARM and MEASURE alike)
      if (fstart) begin
         state_d      = MEASURE;
         lines_d      = '0;
         err_d        = 1'b0;
         line_seen_d  = 1'b0;
         hblank_cur_d = '0;
      end

      // loss of signal: status drops, last measurement values are kept
      if (expire) begin
         state_d      = ARM;
         lost_d       = 1'b1;
         meas_valid_d = 1'b0;
         locked_d     = 1'b0;
         frame_cnt_d  = '0;
         stable_d     = '0;
      end
   end

   // State and measurement registers
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q        <= ARM;
         pix_q          <= '0;
         hb_q           <= '0;
         vb_q           <= '0;
         per_q          <= '0;
         lines_q        <= '0;
         hsize_cur_q    <= '0;
         hblank_cur_q   <= '0;
         err_q          <= 1'b0;
         line_seen_q    <= 1'b0;
         fstart_d_q     <= 1'b0;
         tmo_q          <= '0;
         stable_q       <= '0;
         hsize_q        <= '0;
         vsize_q        <= '0;
         hblank_q       <= '0;
         vblank_q       <= '0;
         frame_period_q <= '0;
         frame_cnt_q    <= '0;
         meas_valid_q   <= 1'b0;
         line_err_q     <= 1'b0;
         locked_q       <= 1'b0;
         update_q       <= 1'b0;
         changed_q      <= 1'b0;
         lost_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         pix_q          <= pix_d;
         hb_q           <= hb_d;
         vb_q           <= vb_d;
         per_q          <= per_d;
         lines_q        <= lines_d;
         hsize_cur_q    <= hsize_cur_d;
         hblank_cur_q   <= hblank_cur_d;
         err_q          <= err_d;
         line_seen_q    <= line_seen_d;
         fstart_d_q     <= fstart_d_d;
         tmo_q          <= tmo_d;
         stable_q       <= stable_d;
         hsize_q        <= hsize_d;
         vsize_q        <= vsize_d;
         hblank_q       <= hblank_d;
         vblank_q       <= vblank_d;
         frame_period_q <= frame_period_d;
         frame_cnt_q    <= frame_cnt_d;
         meas_valid_q   <= meas_valid_d;
         line_err_q     <= line_err_d;
         locked_q       <= locked_d;
         update_q       <= update_d;
         changed_q      <= changed_d;
         lost_q         <= lost_d;
      end
   end

   assign mon.hsize        = hsize_q;
   assign mon.vsize        = vsize_q;
   assign mon.hblank       = hblank_q;
   assign mon.vblank       = vblank_q;
   assign mon.frame_period = frame_period_q;
   assign mon.frame_cnt    = frame_cnt_q;
   assign mon.meas_valid   = meas_valid_q;
   assign mon.line_err     = line_err_q;
   assign mon.locked       = locked_q;
   assign mon.update       = update_q;
   assign mon.changed      = changed_q;
   assign mon.lost         = lost_q;
endmodule

// File: tb/tb_frame_timing_monitor.sv
// Bench for frame_timing_monitor: table of frames with expected published
// measurements, scoreboard queue popped on every update pulse, plus reset,
// timeout and counter-saturation sequences.
module tb_frame_timing_monitor;
   localparam int TMO = 64;

   logic clk_in = 1'b0;
   logic reset  = 1'b1;
   always #5 clk_in = ~clk_in;

   frame_timing_monitor_if #(.TIMER_BITS(32)) mif();
   frame_timing_monitor_if #(.TIMER_BITS(4))  nif();

   assign nif.dvalid = mif.dvalid;
   assign nif.lvalid = mif.lvalid;
   assign nif.fvalid = mif.fvalid;

   frame_timing_monitor #(.TIMER_BITS(32), .STABLE_FRAMES(3), .TIMEOUT(TMO)) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .mon    (mif)
   );

   frame_timing_monitor #(.TIMER_BITS(4), .STABLE_FRAMES(3), .TIMEOUT(TMO)) dut_narrow (
      .clk_in (clk_in),
      .reset  (reset),
      .mon    (nif)
   );

   // one frame of stimulus and the measurement it must publish
   typedef struct {
      int nl, px, bad, hb, vb;
      int h, v, hbl, vbl, per;
      bit err, chg, lck;
      int cnt;
   } vec_t;

   vec_t tbl[14];
   vec_t sbq[$];
   vec_t e;
   int   checks = 0;
   int   errors = 0;
   int   pub_idx = 0;
   bit   narrow_phase = 1'b0;
   bit   narrow_seen  = 1'b0;

   function automatic vec_t mk(input int nl, px, bad, hb, vb, h, v, hbl, vbl, per,
                               input bit err, chg, lck, input int cnt);
      vec_t r;
      r.nl = nl; r.px = px; r.bad = bad; r.hb = hb; r.vb = vb;
      r.h = h; r.v = v; r.hbl = hbl; r.vbl = vbl; r.per = per;
      r.err = err; r.chg = chg; r.lck = lck; r.cnt = cnt;
      return r;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_in(input logic d, input logic l, input logic f);
      mif.dvalid = d;
      mif.lvalid = l;
      mif.fvalid = f;
   endtask

   // nl lines of px pixels (line 'bad' one pixel short), hb-cycle gaps, vb low after
   task automatic drive_frame(input int nl, px, bad, hb, vb);
      for (int l = 0; l < nl; l++) begin
         for (int p = 0; p < ((l == bad) ? px - 1 : px); p++) begin
            set_in(1'b1, 1'b1, 1'b1);
            @(negedge clk_in);
         end
         if (l < nl - 1) begin
            for (int g = 0; g < hb; g++) begin
               set_in(1'b0, 1'b0, 1'b1);
               @(negedge clk_in);
            end
         end
      end
      set_in(1'b0, 1'b0, 1'b0);
      repeat (vb) @(negedge clk_in);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_hsize"},  mif.hsize, 0);
      chk({tag, "_vsize"},  mif.vsize, 0);
      chk({tag, "_hblank"}, mif.hblank, 0);
      chk({tag, "_vblank"}, mif.vblank, 0);
      chk({tag, "_period"}, mif.frame_period, 0);
      chk({tag, "_fcnt"},   mif.frame_cnt, 0);
      chk({tag, "_mvalid"}, mif.meas_valid, 0);
      chk({tag, "_lerr"},   mif.line_err, 0);
      chk({tag, "_locked"}, mif.locked, 0);
      chk({tag, "_update"}, mif.update, 0);
      chk({tag, "_changed"},mif.changed, 0);
      chk({tag, "_lost"},   mif.lost, 0);
   endtask

   // Scoreboard: every update pulse must match the oldest outstanding frame
   always @(negedge clk_in) begin
      if (!reset) begin
         if (mif.update) begin
            chk("update_expected", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               chk($sformatf("pub%0d_hsize", pub_idx),  mif.hsize, e.h);
               chk($sformatf("pub%0d_vsize", pub_idx),  mif.vsize, e.v);
               chk($sformatf("pub%0d_hblank", pub_idx), mif.hblank, e.hbl);
               chk($sformatf("pub%0d_vblank", pub_idx), mif.vblank, e.vbl);
               chk($sformatf("pub%0d_period", pub_idx), mif.frame_period, e.per);
               chk($sformatf("pub%0d_lerr", pub_idx),   mif.line_err, e.err);
               chk($sformatf("pub%0d_changed", pub_idx),mif.changed, e.chg);
               chk($sformatf("pub%0d_locked", pub_idx), mif.locked, e.lck);
               chk($sformatf("pub%0d_fcnt", pub_idx),   mif.frame_cnt, e.cnt);
               chk($sformatf("pub%0d_mvalid", pub_idx), mif.meas_valid, 1);
            end
            pub_idx++;
         end else if (mif.changed) begin
            chk("changed_with_update", mif.update, 1);
         end
      end
   end

   // Narrow instance: 20-pixel lines must saturate, not wrap
   always @(negedge clk_in) begin
      if (narrow_phase && nif.update) begin
         narrow_seen = 1'b1;
         chk("narrow_hsize_sat",  nif.hsize, 15);
         chk("narrow_period_sat", nif.frame_period, 15);
         chk("narrow_vsize",      nif.vsize, 1);
         chk("narrow_vblank",     nif.vblank, 10);
      end
   end

   initial begin
      int n;
      set_in(1'b0, 1'b0, 1'b0);

      //           nl px bad hb vb   h  v hbl vbl per  err chg lck cnt
      tbl[0]  = mk(4, 8, -1, 3, 10,  8, 4, 3, 10, 51,  0, 0, 0, 1);
      tbl[1]  = mk(4, 8, -1, 3, 10,  8, 4, 3, 10, 51,  0, 0, 0, 2);
      tbl[2]  = mk(4, 8, -1, 3, 10,  8, 4, 3, 10, 51,  0, 0, 1, 3);
      tbl[3]  = mk(4, 8, -1, 3, 10,  8, 4, 3, 10, 51,  0, 0, 1, 4);
      tbl[4]  = mk(6, 8, -1, 1, 8,   8, 6, 1, 8,  61,  0, 1, 0, 5);
      tbl[5]  = mk(6, 8, -1, 1, 8,   8, 6, 1, 8,  61,  0, 0, 0, 6);
      tbl[6]  = mk(6, 8, -1, 1, 8,   8, 6, 1, 8,  61,  0, 0, 0, 7);
      tbl[7]  = mk(6, 8, -1, 1, 8,   8, 6, 1, 8,  61,  0, 0, 1, 8);
      tbl[8]  = mk(4, 8, -1, 3, 10,  8, 4, 3, 10, 51,  0, 1, 0, 9);
      tbl[9]  = mk(4, 8, 2,  3, 10,  8, 4, 3, 10, 50,  1, 1, 0, 10);
      tbl[10] = mk(4, 8, -1, 3, 10,  8, 4, 3, 10, 51,  0, 1, 0, 11);
      tbl[11] = mk(4, 8, -1, 3, 10,  8, 4, 3, 10, 51,  0, 0, 0, 12);
      tbl[12] = mk(4, 8, -1, 3, 10,  8, 4, 3, 10, 51,  0, 0, 0, 13);
      tbl[13] = mk(4, 8, -1, 3, 10,  8, 4, 3, 10, 51,  0, 0, 1, 14);

      repeat (2) @(negedge clk_in);
      check_zero("por");
      reset = 1'b0;
      repeat (3) @(negedge clk_in);

      // one published frame, then reset in the middle of the next one
      sbq.push_back(mk(4, 8, -1, 3, 10, 8, 4, 3, 10, 51, 0, 0, 0, 1));
      drive_frame(4, 8, -1, 3, 10);
      repeat (5) begin
         set_in(1'b1, 1'b1, 1'b1);
         @(negedge clk_in);
      end
      chk("pre_reset_published", sbq.size(), 0);
      chk("pre_reset_mvalid", mif.meas_valid, 1);
      reset = 1'b1;
      set_in(1'b0, 1'b0, 1'b0);
      @(negedge clk_in);
      check_zero("midrst");
      reset = 1'b0;
      repeat (10) @(negedge clk_in);

      // table: first frame starts in ARM, each later frame start publishes the previous one
      for (int i = 0; i < 14; i++) begin
         sbq.push_back(tbl[i]);
         drive_frame(tbl[i].nl, tbl[i].px, tbl[i].bad, tbl[i].hb, tbl[i].vb);
      end
      // closing frame publishes tbl[13]; fvalid then stays low until timeout
      drive_frame(4, 8, -1, 3, 0);
      chk("table_all_published", sbq.size(), 0);

      // lost arrives TIMEOUT cycles after the frame start seen through two input stages
      n = 41;
      while (!mif.lost && n < 200) begin
         @(negedge clk_in);
         n++;
      end
      chk("lost_cycle", n, TMO + 2);
      chk("lost_mvalid", mif.meas_valid, 0);
      chk("lost_fcnt", mif.frame_cnt, 0);
      chk("lost_locked", mif.locked, 0);
      chk("lost_keeps_hsize", mif.hsize, 8);
      chk("lost_keeps_vsize", mif.vsize, 4);
      @(negedge clk_in);
      chk("lost_one_cycle", mif.lost, 0);

      // single 20-pixel line frames: hblank 0, no change after loss, narrow saturates
      narrow_phase = 1'b1;
      sbq.push_back(mk(1, 20, -1, 0, 10, 20, 1, 0, 10, 30, 0, 0, 0, 1));
      drive_frame(1, 20, -1, 0, 10);
      drive_frame(1, 20, -1, 0, 2);
      chk("narrow_update_seen", narrow_seen, 1);
      chk("final_all_published", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
